// File: rtl/regfile_scanner_pkg.sv
// Shared types and constants for the register-bank scanner.
// Holds the bank geometry, the scanner state encoding and the beat layout.
package regfile_scanner_pkg;

    localparam int REG_DW = 8;
    localparam int REG_AW = 4;

    // Scanner FSM states; the encoding is also visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } scan_state_t;

    // One streamed beat: register address, captured contents, end-of-window flag.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
        logic              last;
    } beat_t;

endpackage

// File: rtl/regfile_scanner_addr_ctr.sv
// Loadable address up-counter for the scanner.
// Loads FIRST_ADDR, steps by one on request and flags when it sits on
// LAST_ADDR. It holds at LAST_ADDR instead of wrapping.
module regfile_scanner_addr_ctr
    import regfile_scanner_pkg::*;
#(
    parameter int AW         = REG_AW,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    output logic [AW-1:0] cnt,
    output logic          at_last
);

    localparam logic [AW-1:0] FIRST_A = AW'(FIRST_ADDR);
    localparam logic [AW-1:0] LAST_A  = AW'(LAST_ADDR);

    // Terminal compare drives both the beat's last flag and the no-wrap guard.
    assign at_last = (cnt == LAST_A);

    // Counter register: reset/load to the window start, step until the window end.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= FIRST_A;
        end else if (load) begin
            cnt <= FIRST_A;
        end else if (inc && !at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scanner.sv
// Register-bank scanner: on start, walks the bank read port from FIRST_ADDR
// to LAST_ADDR and streams {addr, data, last} beats out.
// Optional build macro: REGFILE_SCANNER_CHECKSUM_EN adds the chk output
// (XOR of all handshaked out_data values of the current scan).
//
// Stream handshake: a beat transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid is high, out_addr, out_data and
// out_last are held unchanged until that transfer; out_valid never drops
// without a transfer (except on rst). out_ready may change freely.
module regfile_scanner
    import regfile_scanner_pkg::*;
#(
    parameter int DW         = REG_DW,
    parameter int AW         = REG_AW,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output scan_state_t   dbg_state
`ifdef REGFILE_SCANNER_CHECKSUM_EN
    ,
    output logic [DW-1:0] chk
`endif
);

    localparam logic [AW-1:0] FIRST_A = AW'(FIRST_ADDR);

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic          ctr_load;
    logic          ctr_inc;
    logic [AW-1:0] cnt;
    logic          at_last;
    logic          hs;

    assign hs        = out_valid && out_ready;
    assign dbg_state = state;

    regfile_scanner_addr_ctr #(
        .AW         (AW),
        .FIRST_ADDR (FIRST_ADDR),
        .LAST_ADDR  (LAST_ADDR)
    ) u_addr_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (ctr_load),
        .inc     (ctr_inc),
        .cnt     (cnt),
        .at_last (at_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter control and the combinational status outputs.
    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rf_ra     = cnt;
        case (state)
            IDLE: begin
                rf_ra = FIRST_A;
                if (start) begin
                    ctr_load  = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                busy = 1'b1;
                if (hs) begin
                    if (out_last) begin
                        state_nxt = FIN;
                    end else begin
                        ctr_inc   = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat register: snapshot the bank in READ, hold through SEND until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (state == READ) begin
            out_valid <= 1'b1;
            out_addr  <= cnt;
            out_data  <= rf_rd;
            out_last  <= at_last;
        end else if (state == SEND && hs) begin
            out_valid <= 1'b0;
        end
    end

`ifdef REGFILE_SCANNER_CHECKSUM_EN
    // Running XOR of transferred payloads; cleared when a new scan is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk <= '0;
        end else if (state == IDLE && start) begin
            chk <= '0;
        end else if (state == SEND && hs) begin
            chk <= chk ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_scanner.sv
// Self-checking bench for regfile_scanner: a table of expected beats for the
// full-window scan, a scoreboard queue for the stalled scan, and directed
// sequences for snapshot, ignored start, mid-scan reset and a one-entry window.
module tb_regfile_scanner;
    import regfile_scanner_pkg::*;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start1;
    logic        busy, busy1, done, done1;
    logic [3:0]  rf_ra, rf_ra1;
    logic [7:0]  rf_rd, rf_rd1;
    logic        out_valid, out_valid1, out_ready, out_ready1;
    logic [3:0]  out_addr, out_addr1;
    logic [7:0]  out_data, out_data1;
    logic        out_last, out_last1;
    scan_state_t dbg_state, dbg_state1;
`ifdef REGFILE_SCANNER_CHECKSUM_EN
    logic [7:0]  chk, chk1;
`endif

    logic [7:0]  bank [16];
    vec_t        vecs [16];
    logic [12:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    assign rf_rd  = bank[rf_ra];
    assign rf_rd1 = bank[rf_ra1];

    regfile_scanner u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .dbg_state(dbg_state)
`ifdef REGFILE_SCANNER_CHECKSUM_EN
        , .chk(chk)
`endif
    );

    regfile_scanner #(.FIRST_ADDR(3), .LAST_ADDR(3)) u_one (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rf_ra(rf_ra1), .rf_rd(rf_rd1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_addr(out_addr1), .out_data(out_data1), .out_last(out_last1),
        .dbg_state(dbg_state1)
`ifdef REGFILE_SCANNER_CHECKSUM_EN
        , .chk(chk1)
`endif
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 0) ? 8'h00 : 8'(8'h10 + i);
    endfunction

    task automatic load_bank();
        for (int i = 0; i < 16; i++) bank[i] = init_val(i);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a beat to be presented; an expired bound is a failure.
    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, 32'(out_valid), 32'd1);
    endtask

    // Receive one beat with out_ready already high, then step past its transfer.
    task automatic recv(input logic [3:0] a, input logic [7:0] d, input logic l);
        wait_valid($sformatf("beat%0d", a));
        check($sformatf("beat%0d addr", a), 32'(out_addr), 32'(a));
        check($sformatf("beat%0d data", a), 32'(out_data), 32'(d));
        check($sformatf("beat%0d last", a), 32'(out_last), 32'(l));
        @(negedge clk);
    endtask

    task automatic start_scan();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, " done"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int          t0;
        logic [7:0]  exp_chk;
        logic [12:0] e;
        logic [12:0] prev_beat;
        logic        prev_stall;
        logic        pat [4];
        int          k;

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        load_bank();
        for (int i = 0; i < 16; i++) begin
            vecs[i].addr = 4'(i);
            vecs[i].data = init_val(i);
            vecs[i].last = (i == 15);
        end
        rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst out_addr", 32'(out_addr), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst rf_ra", 32'(rf_ra), 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        check("rst one rf_ra", 32'(rf_ra1), 32'd3);
        rst = 1'b0;

        // Full scan, out_ready held high, compared against the vector table.
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("s1 busy after start", 32'(busy), 32'd1);
        check("s1 no early valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("s1 first valid latency", 32'(out_valid), 32'd1);
        exp_chk = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_chk ^= vecs[i].data;
            recv(vecs[i].addr, vecs[i].data, vecs[i].last);
        end
        check("s1 done", 32'(done), 32'd1);
        check("s1 busy at done", 32'(busy), 32'd0);
        check("s1 valid at done", 32'(out_valid), 32'd0);
        check("s1 scan length", 32'(cyc - t0), 32'd33);
`ifdef REGFILE_SCANNER_CHECKSUM_EN
        check("s1 chk", 32'(chk), 32'(exp_chk));
`endif
        @(negedge clk);
        check("s1 done one cycle", 32'(done), 32'd0);
        check("s1 idle", 32'(dbg_state), 32'(IDLE));

        // Stalled scan: out_ready follows 1,0,0,1,...; scoreboard keeps order.
        for (int i = 0; i < 16; i++) exp_q.push_back({vecs[i].addr, vecs[i].data, vecs[i].last});
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        prev_stall = 1'b0;
        prev_beat = '0;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall) begin
                check("s2 hold valid", 32'(out_valid), 32'd1);
                check("s2 hold payload", 32'({out_addr, out_data, out_last}), 32'(prev_beat));
            end
            out_ready = pat[k % 4];
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("s2 beat", 32'({out_addr, out_data, out_last}), 32'(e));
            end
            prev_stall = out_valid && !out_ready;
            prev_beat = {out_addr, out_data, out_last};
            k++;
        end
        check("s2 all beats", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        out_ready = 1'b1;
        wait_done("s2");

        // Snapshot: bank writes while beat 5 is held do not alter it.
        start_scan();
        for (int i = 0; i < 5; i++) recv(vecs[i].addr, vecs[i].data, vecs[i].last);
        wait_valid("s3 beat5");
        out_ready = 1'b0;
        bank[5] = 8'hAA;
        bank[6] = 8'hBB;
        check("s3 beat5 addr", 32'(out_addr), 32'd5);
        check("s3 beat5 data", 32'(out_data), 32'h15);
        @(negedge clk);
        check("s3 beat5 held data", 32'(out_data), 32'h15);
        out_ready = 1'b1;
        @(negedge clk);
        recv(4'd6, 8'hBB, 1'b0);
        for (int i = 7; i < 16; i++) recv(vecs[i].addr, vecs[i].data, vecs[i].last);
        wait_done("s3");
        load_bank();

        // Start pulsed during beat 3 is ignored; exactly one done.
        done_cnt = 0;
        start_scan();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) wait_valid("s4 beat3");
            start = (i == 3);
            recv(vecs[i].addr, vecs[i].data, vecs[i].last);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("s4 done count", 32'(done_cnt), 32'd1);
        check("s4 back idle", 32'(dbg_state), 32'(IDLE));

        // Reset during a stall on beat 7 drops it; next scan restarts at 0.
        start_scan();
        for (int i = 0; i < 7; i++) recv(vecs[i].addr, vecs[i].data, vecs[i].last);
        wait_valid("s5 beat7");
        out_ready = 1'b0;
        @(negedge clk);
        check("s5 stalled addr", 32'(out_addr), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5 valid", 32'(out_valid), 32'd0);
        check("s5 busy", 32'(busy), 32'd0);
        check("s5 done", 32'(done), 32'd0);
        check("s5 rf_ra", 32'(rf_ra), 32'd0);
        check("s5 out_data", 32'(out_data), 32'd0);
        check("s5 out_addr", 32'(out_addr), 32'd0);
        check("s5 state", 32'(dbg_state), 32'(IDLE));
        out_ready = 1'b1;
        start_scan();
        for (int i = 0; i < 16; i++) recv(vecs[i].addr, vecs[i].data, vecs[i].last);
        wait_done("s5");

        // One-entry window at address 3.
        @(negedge clk);
        start1 = 1'b1;
        out_ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (!out_valid1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("s6 valid", 32'(out_valid1), 32'd1);
        check("s6 addr", 32'(out_addr1), 32'd3);
        check("s6 data", 32'(out_data1), 32'h13);
        check("s6 last", 32'(out_last1), 32'd1);
        @(negedge clk);
        check("s6 done", 32'(done1), 32'd1);
        check("s6 valid after", 32'(out_valid1), 32'd0);
`ifdef REGFILE_SCANNER_CHECKSUM_EN
        check("s6 chk", 32'(chk1), 32'h13);
`endif
        @(negedge clk);
        check("s6 no second beat", 32'(out_valid1), 32'd0);
        check("s6 done pulse", 32'(done1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
